// File: rtl/ntt_tf_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ntt_tf_sequencer
// Description : Twiddle-factor sequencer for the Dilithium forward NTT. Walks
//               layers 0..7, drives three twiddle ROM addresses and presents
//               one 4-lane twiddle word per beat over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_tf_sequencer #(
    parameter int LAYER_GAP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [5:0]  tf0_A,
    output logic [4:0]  tf1_A,
    output logic [4:0]  tf2_A,
    input  logic [22:0] tf0_Q,
    input  logic [45:0] tf1_Q,
    input  logic [91:0] tf2_Q,
    output logic [91:0] tw,
    output logic        tf_valid,
    input  logic        tf_ready,
    output logic [2:0]  tf_layer,
    output logic [4:0]  tf_beat,
    output logic        tf_last,
    output logic        busy,
    output logic        done
);

    localparam int C_GAP_W = (LAYER_GAP > 1) ? $clog2(LAYER_GAP) : 1;
    localparam logic [C_GAP_W-1:0] C_GAP_LOAD = C_GAP_W'((LAYER_GAP > 0) ? LAYER_GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_layer;
    logic [4:0]          r_beat;
    logic [C_GAP_W-1:0]  r_gap_cnt;
    logic                r_valid;
    logic [2:0]          r_out_layer;
    logic [4:0]          r_out_beat;
    logic                r_done;

    logic                w_adv;
    logic                w_issue;
    logic                w_hs;
    logic                w_start_acc;
    logic                w_layer_inc;
    logic                w_done_nxt;
    logic [2:0]          w_a_layer;
    logic [4:0]          w_a_beat;
    logic [2:0]          w_shift;
    logic [5:0]          w_tf0_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_adv       = !r_valid || tf_ready;
        w_issue     = (r_state == S_RUN) && w_adv;
        w_hs        = r_valid && tf_ready;
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_layer_inc = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The done cycle is still part of the transform; start is ignored there.
                if (start && !r_done) begin
                    w_state_nxt = S_RUN;
                    w_start_acc = 1'b1;
                end
            end
            S_RUN: begin
                if (w_issue && (r_beat == 5'd31)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_hs) begin
                    if (r_layer == 3'd7) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (LAYER_GAP == 0) begin
                        w_state_nxt = S_RUN;
                        w_layer_inc = 1'b1;
                    end else begin
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_RUN;
                    w_layer_inc = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_layer     <= 3'd0;
            r_beat      <= 5'd0;
            r_gap_cnt   <= '0;
            r_valid     <= 1'b0;
            r_out_layer <= 3'd0;
            r_out_beat  <= 5'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_start_acc) begin
                r_layer <= 3'd0;
                r_beat  <= 5'd0;
            end else if (w_layer_inc) begin
                r_layer <= r_layer + 3'd1;
                r_beat  <= 5'd0;
            end else if (w_issue) begin
                r_beat  <= r_beat + 5'd1;
            end
            if (r_state == S_DRAIN) begin
                r_gap_cnt <= C_GAP_LOAD;
            end else if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
            if (w_issue) begin
                r_valid     <= 1'b1;
                r_out_layer <= r_layer;
                r_out_beat  <= r_beat;
            end else if (w_hs) begin
                r_valid     <= 1'b0;
            end
        end
    end

    // During a stall the ROM re-reads the presented beat so Q stays stable.
    always_comb begin
        w_a_layer  = w_issue ? r_layer : r_out_layer;
        w_a_beat   = w_issue ? r_beat  : r_out_beat;
        w_shift    = 3'd5 - w_a_layer;
        w_tf0_base = (6'd1 << w_a_layer) - 6'd1;
        tf0_A      = 6'd0;
        tf1_A      = 5'd0;
        tf2_A      = 5'd0;
        if (w_a_layer < 3'd6) begin
            tf0_A = w_tf0_base + ({1'b0, w_a_beat} >> w_shift);
        end else if (w_a_layer == 3'd6) begin
            tf1_A = w_a_beat;
        end else begin
            tf2_A = w_a_beat;
        end
    end

    always_comb begin
        if (r_out_layer == 3'd7) begin
            tw = tf2_Q;
        end else if (r_out_layer == 3'd6) begin
            tw = {tf1_Q[45:23], tf1_Q[45:23], tf1_Q[22:0], tf1_Q[22:0]};
        end else begin
            tw = {4{tf0_Q}};
        end
    end

    assign tf_valid = r_valid;
    assign tf_layer = r_out_layer;
    assign tf_beat  = r_out_beat;
    assign tf_last  = r_valid && (r_out_layer == 3'd7) && (r_out_beat == 5'd31);
    assign busy     = (r_state != S_IDLE) || r_valid;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ntt_tf_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntt_tf_sequencer
// Description : Self-checking bench for ntt_tf_sequencer (gap 4 and gap 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_tf_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  layer;
        logic [4:0]  beat;
        logic [5:0]  a0;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [91:0] tw;
    } beat_t;

    typedef struct {
        int layer;
        int beat;
        int a0;
        int a1;
        int a2;
    } avec_t;

    beat_t sb_q[$];

    // ROM contents
    function automatic logic [22:0] rom0(input logic [5:0] a);
        if (a == 6'd0) return 23'd4808194;
        return 23'((int'(a) * 131071 + 977) % 8380417);
    endfunction
    function automatic logic [45:0] rom1(input logic [4:0] a);
        return {23'(int'(a) * 40503 + 11), 23'(int'(a) * 70001 + 3)};
    endfunction
    function automatic logic [91:0] rom2(input logic [4:0] a);
        return {23'(int'(a) * 1000 + 4), 23'(int'(a) * 2000 + 3),
                23'(int'(a) * 3000 + 2), 23'(int'(a) * 4000 + 1)};
    endfunction

    function automatic logic [5:0] exp_a0(input int l, input int b);
        if (l < 6) return 6'(((1 << l) - 1) + (b >> (5 - l)));
        return 6'd0;
    endfunction
    function automatic logic [91:0] exp_tw(input int l, input int b);
        logic [45:0] w;
        if (l < 6) return {4{rom0(exp_a0(l, b))}};
        w = rom1(5'(b));
        if (l == 6) return {w[45:23], w[45:23], w[22:0], w[22:0]};
        return rom2(5'(b));
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_run();
        beat_t e;
        for (int l = 0; l < 8; l++) begin
            for (int b = 0; b < 32; b++) begin
                e.layer = 3'(l);
                e.beat  = 5'(b);
                e.a0    = exp_a0(l, b);
                e.a1    = (l == 6) ? 5'(b) : 5'd0;
                e.a2    = (l == 7) ? 5'(b) : 5'd0;
                e.tw    = exp_tw(l, b);
                sb_q.push_back(e);
            end
        end
    endtask

    // ---------------- DUT A (LAYER_GAP = 4) ----------------
    logic        rst_n_a, start_a, ready_a;
    logic [5:0]  a0_a, la0_a;
    logic [4:0]  a1_a, a2_a, la1_a, la2_a;
    logic [22:0] q0_a;
    logic [45:0] q1_a;
    logic [91:0] q2_a, tw_a;
    logic        valid_a, last_a, busy_a, done_a;
    logic [2:0]  layer_a;
    logic [4:0]  beat_a;

    ntt_tf_sequencer #(.LAYER_GAP(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a),
        .tf0_A(a0_a), .tf1_A(a1_a), .tf2_A(a2_a),
        .tf0_Q(q0_a), .tf1_Q(q1_a), .tf2_Q(q2_a),
        .tw(tw_a), .tf_valid(valid_a), .tf_ready(ready_a),
        .tf_layer(layer_a), .tf_beat(beat_a), .tf_last(last_a),
        .busy(busy_a), .done(done_a)
    );

    always @(posedge clk) begin
        q0_a  <= rom0(a0_a);
        q1_a  <= rom1(a1_a);
        q2_a  <= rom2(a2_a);
        la0_a <= a0_a;
        la1_a <= a1_a;
        la2_a <= a2_a;
    end

    // ---------------- DUT B (LAYER_GAP = 0) ----------------
    logic        rst_n_b, start_b, ready_b;
    logic [5:0]  a0_b;
    logic [4:0]  a1_b, a2_b;
    logic [22:0] q0_b;
    logic [45:0] q1_b;
    logic [91:0] q2_b, tw_b;
    logic        valid_b, last_b, busy_b, done_b;
    logic [2:0]  layer_b;
    logic [4:0]  beat_b;

    ntt_tf_sequencer #(.LAYER_GAP(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b),
        .tf0_A(a0_b), .tf1_A(a1_b), .tf2_A(a2_b),
        .tf0_Q(q0_b), .tf1_Q(q1_b), .tf2_Q(q2_b),
        .tw(tw_b), .tf_valid(valid_b), .tf_ready(ready_b),
        .tf_layer(layer_b), .tf_beat(beat_b), .tf_last(last_b),
        .busy(busy_b), .done(done_b)
    );

    always @(posedge clk) begin
        q0_b <= rom0(a0_b);
        q1_b <= rom1(a1_b);
        q2_b <= rom2(a2_b);
    end

    // ---------------- monitor A: scoreboard, stall stability, timing ----------------
    logic        mon_a = 1'b0;
    logic        prev_stall_a = 1'b0;
    logic [91:0] prev_tw_a;
    logic [7:0]  prev_id_a;
    int beats_a, lasts_a, stalls_a, busy_low_a;
    int first_valid_a = -1;
    int done_cyc_a = -1;
    int e0_a = 32'h7fffffff;
    logic [5:0]  log_a0 [256];
    logic [4:0]  log_a1 [256];
    logic [4:0]  log_a2 [256];
    logic [91:0] log_tw [256];

    always @(negedge clk) begin
        beat_t e;
        if (mon_a) begin
            if (prev_stall_a) begin
                chk("stall_hold_tw", 128'(tw_a), 128'(prev_tw_a));
                chk("stall_hold_id", 128'({layer_a, beat_a}), 128'(prev_id_a));
            end
            if (valid_a && first_valid_a < 0) first_valid_a = cyc;
            if (done_a && done_cyc_a < 0) done_cyc_a = cyc;
            if (cyc >= e0_a && done_cyc_a < 0 && !busy_a) busy_low_a++;
            if (valid_a && !ready_a) stalls_a++;
            if (valid_a && ready_a) begin
                if (last_a) lasts_a++;
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 128'(sb_q.size()), 128'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("beat_id", 128'({layer_a, beat_a}), 128'({e.layer, e.beat}));
                    chk("tw", 128'(tw_a), 128'(e.tw));
                    chk("rom_addr", 128'({la0_a, la1_a, la2_a}), 128'({e.a0, e.a1, e.a2}));
                    log_a0[{layer_a, beat_a}] = la0_a;
                    log_a1[{layer_a, beat_a}] = la1_a;
                    log_a2[{layer_a, beat_a}] = la2_a;
                    log_tw[{layer_a, beat_a}] = tw_a;
                    beats_a++;
                end
            end
            prev_stall_a = valid_a && !ready_a;
            prev_tw_a    = tw_a;
            prev_id_a    = {layer_a, beat_a};
        end else begin
            prev_stall_a = 1'b0;
        end
    end

    // ---------------- monitor B ----------------
    logic mon_b = 1'b0;
    int beats_b = 0;
    int dones_b = 0;
    int done_cyc_b = -1;
    int e0_b = 0;

    always @(negedge clk) begin
        if (mon_b) begin
            if (done_b && done_cyc_b < 0) done_cyc_b = cyc;
            if (done_b) dones_b++;
            if (valid_b && ready_b) begin
                chk("b_beat_id", 128'({layer_b, beat_b}), 128'(beats_b));
                chk("b_tw", 128'(tw_b), 128'(exp_tw(beats_b / 32, beats_b % 32)));
                beats_b++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic reset_stats_a();
        beats_a       = 0;
        lasts_a       = 0;
        stalls_a      = 0;
        busy_low_a    = 0;
        first_valid_a = -1;
        done_cyc_a    = -1;
        e0_a          = 32'h7fffffff;
    endtask

    task automatic start_run_a();
        reset_stats_a();
        push_run();
        mon_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b1;
        e0_a    = cyc + 1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int limit);
        int n = 0;
        while (!done_a && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout_a", 128'(done_a), 128'd1);
        #1;
    endtask

    task automatic wait_beat_a(input int l, input int b, input int limit);
        int n = 0;
        while (!(valid_a && layer_a == 3'(l) && beat_a == 5'(b)) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("wait_beat_timeout", 128'(valid_a && layer_a == 3'(l) && beat_a == 5'(b)), 128'd1);
    endtask

    logic  rand_on = 1'b0;
    avec_t atab[14];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        atab[0]  = '{0, 0, 0, 0, 0};
        atab[1]  = '{0, 31, 0, 0, 0};
        atab[2]  = '{1, 15, 1, 0, 0};
        atab[3]  = '{1, 16, 2, 0, 0};
        atab[4]  = '{2, 0, 3, 0, 0};
        atab[5]  = '{2, 8, 4, 0, 0};
        atab[6]  = '{2, 16, 5, 0, 0};
        atab[7]  = '{2, 31, 6, 0, 0};
        atab[8]  = '{3, 17, 11, 0, 0};
        atab[9]  = '{4, 5, 17, 0, 0};
        atab[10] = '{5, 0, 31, 0, 0};
        atab[11] = '{5, 31, 62, 0, 0};
        atab[12] = '{6, 5, 0, 5, 0};
        atab[13] = '{7, 31, 0, 0, 31};

        rst_n_a = 1'b0; start_a = 1'b0; ready_a = 1'b1;
        rst_n_b = 1'b0; start_b = 1'b0; ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_valid", 128'(valid_a), 128'd0);
        chk("rst_layer_beat", 128'({layer_a, beat_a}), 128'd0);
        chk("rst_busy_done_last", 128'({busy_a, done_a, last_a}), 128'd0);
        chk("rst_addrs", 128'({a0_a, a1_a, a2_a}), 128'd0);

        // always-ready transform
        start_run_a();
        wait_done_a(400);
        chk("first_valid_lat", 128'(first_valid_a - e0_a), 128'd1);
        chk("done_lat", 128'(done_cyc_a - e0_a), 128'd292);
        chk("busy_low_before_done", 128'(busy_low_a), 128'd0);
        chk("busy_at_done", 128'(busy_a), 128'd0);
        chk("beats_total", 128'(beats_a), 128'd256);
        chk("last_once", 128'(lasts_a), 128'd1);
        chk("sb_empty", 128'(sb_q.size()), 128'd0);
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("addr_tab_l%0d_b%0d", atab[i].layer, atab[i].beat),
                128'({log_a0[atab[i].layer * 32 + atab[i].beat],
                      log_a1[atab[i].layer * 32 + atab[i].beat],
                      log_a2[atab[i].layer * 32 + atab[i].beat]}),
                128'({6'(atab[i].a0), 5'(atab[i].a1), 5'(atab[i].a2)}));
        end
        chk("tw_layer0_lanes", 128'(log_tw[0]), 128'({4{23'd4808194}}));

        // random ready
        start_run_a();
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk); #1;
                    if (rand_on) ready_a = 1'($urandom_range(0, 1));
                end
            end
            begin
                wait_done_a(3000);
                rand_on = 1'b0;
            end
        join
        ready_a = 1'b1;
        chk("rand_beats_total", 128'(beats_a), 128'd256);
        chk("rand_last_once", 128'(lasts_a), 128'd1);
        chk("rand_sb_empty", 128'(sb_q.size()), 128'd0);
        chk("rand_stalls_seen", 128'(stalls_a > 0), 128'd1);

        // stall in DRAIN at layer 6 beat 31
        start_run_a();
        wait_beat_a(6, 30, 400);
        @(posedge clk); #1;
        ready_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("drain_hold", 128'({valid_a, layer_a, beat_a}), 128'({1'b1, 3'd6, 5'd31}));
        end
        @(posedge clk); #1;
        ready_a = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("gap_idle", 128'(valid_a), 128'd0);
        end
        @(negedge clk);
        chk("gap_then_l7b0", 128'({valid_a, layer_a, beat_a}), 128'({1'b1, 3'd7, 5'd0}));
        wait_done_a(200);
        chk("drain_beats_total", 128'(beats_a), 128'd256);
        chk("drain_sb_empty", 128'(sb_q.size()), 128'd0);

        // asynchronous reset mid-transform, then restart
        start_run_a();
        wait_beat_a(3, 17, 400);
        mon_a = 1'b0;
        #1;
        rst_n_a = 1'b0;
        #1;
        chk("mid_rst_valid_busy", 128'({valid_a, busy_a, done_a, last_a}), 128'd0);
        chk("mid_rst_layer_beat", 128'({layer_a, beat_a}), 128'd0);
        chk("mid_rst_addrs", 128'({a0_a, a1_a, a2_a}), 128'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n_a = 1'b1;
        start_run_a();
        wait_done_a(400);
        chk("restart_done_lat", 128'(done_cyc_a - e0_a), 128'd292);
        chk("restart_beats_total", 128'(beats_a), 128'd256);
        chk("restart_first_addr", 128'(log_a0[0]), 128'd0);

        // LAYER_GAP = 0 with start pulses during busy and in the done cycle
        mon_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b1;
        e0_b    = cyc + 1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            start_b = (cyc == e0_b + 50) || (cyc == e0_b + 200) || (cyc == e0_b + 264);
        end
        start_b = 1'b0;
        @(negedge clk);
        chk("g0_done_lat", 128'(done_cyc_b - e0_b), 128'd264);
        chk("g0_done_once", 128'(dones_b), 128'd1);
        chk("g0_beats_total", 128'(beats_b), 128'd256);
        chk("g0_idle_after", 128'({busy_b, valid_b}), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
